uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
UART transmitter with a small input FIFO. It serialises bytes onto the SoC `tx` pin, mirroring the bit-level waveform the system bench drives on `rx`. It sits behind the AHB-Lite UART register slave: the slave pushes bytes through a valid/ready handshake, and the block frames and shifts them out at a fixed baud rate. It also serves as a bench-side stimulus generator for the UART receiver.

Parameters:
- CLKS_PER_BIT, 434, sys_clk cycles per UART bit (50 MHz / 115200); must be ≥ 2.
- DATA_BITS, 8, payload bits per frame, 5..8.
- FIFO_DEPTH, 4, FIFO entries; power of 2, ≥ 2.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN = 0).
- STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  synchronous reset, active-high.
- tx_data  in  DATA_BITS  byte to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  FIFO can accept a word (= !fifo_full).
- tx  out  1  serial line, idle high, registered.
- busy  out  1  FSM not in IDLE.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words held in the FIFO.
- fifo_empty  out  1  fifo_count == 0.

Behaviour:
- **Reset** (sys_rst = 1 at an edge):
  - tx = 1, busy = 0, fifo_count = 0, fifo_empty = 1, tx_ready = 1.
  - FSM returns to IDLE; baud counter and bit index are cleared.
  - FIFO contents are discarded.
  - A reset mid-frame drives tx high at that same edge; no partial frame resumes.
- **Push:** occurs when tx_valid && tx_ready at an edge. tx_ready depends only on full, never on a same-cycle pop. tx_valid while !tx_ready is ignored and the word is not consumed.
- **Pop:** occurs when the FSM is in IDLE (or finishing the last stop bit) and the FIFO is not empty.
  - Push and pop at the same edge: count unchanged.
  - Push into an empty FIFO while IDLE: word W is written at edge N, popped at edge N+1, and tx = 0 from edge N+1. Latency is 1 cycle.
- **FSM states and transitions:**
  - IDLE: tx = 1, waits for !fifo_empty.
  - START: tx = 0 for CLKS_PER_BIT cycles.
  - DATA: DATA_BITS bits, LSB first, each CLKS_PER_BIT cycles.
  - PARITY (only if PARITY_EN): bit = XOR(data) ^ PARITY_ODD.
  - STOP: tx = 1 for STOP_BITS × CLKS_PER_BIT cycles.
- **Baud counter:** counts 0..CLKS_PER_BIT-1. The bit or state advances on the edge where the count = CLKS_PER_BIT-1, and the counter wraps to 0. Every bit is exactly CLKS_PER_BIT cycles wide.
- **End of STOP:** if the FIFO is not empty, pop and go directly to START with no idle gap (back-to-back frames). Otherwise go to IDLE.
- **Frame length:** (1 + DATA_BITS + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles.
- **busy:** high from the pop edge through the final stop-bit cycle. It stays high across back-to-back frames.
- **Data capture:** the popped word is captured into a shift register at the pop. tx_data changes after acceptance do not affect the frame. When DATA_BITS < 8, only the low bits are used.
- **Outputs:** all outputs are registered or derived directly from registers; there are no combinational paths from tx_valid to any output.

Test Plan:
- **Reset state:** CLKS_PER_BIT = 50, assert sys_rst 5 cycles → tx = 1, busy = 0, tx_ready = 1, fifo_count = 0.
- **Single frame:** push 0xD9 → tx sequence 0,1,0,0,1,1,0,1,1,1, each level held exactly 50 cycles. tx falls 1 cycle after the push edge. busy drops after 500 cycles.
- **Back-to-back / FIFO full:** hold tx_valid for words 0x01..0x06 →
  - words 1–5 are accepted on consecutive edges (word 1 popped immediately);
  - fifo_count reaches 4 and tx_ready = 0;
  - word 6 is accepted within 2 cycles after frame 1 ends;
  - 6 frames go out with no idle cycles between stop and start; all bytes arrive in order.
- **Parity:** PARITY_EN = 1, push 0xD9 → parity bit = 1 for even parity, 0 for odd. Frame is 550 cycles.
- **Two stop bits:** STOP_BITS = 2, push 0x00 then 0xFF → the stop high lasts 100 cycles between frames.
- **Reset mid-frame:** assert sys_rst during data bit 3 of frame 1 while 2 words are queued →
  - tx = 1 on the next edge and fifo_count = 0;
  - no further frames are sent;
  - a fresh push then transmits correctly.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small valid/ready FIFO. Frames are a start bit, LSB-first data,
// an optional parity bit and one or two stop bits, each CLKS_PER_BIT clocks wide.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          fifo_empty
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

    localparam logic [PtrW:0]   FullCount = FIFO_DEPTH[PtrW:0];
    localparam logic [CntW-1:0] BaudLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      BitLast   = 3'(DATA_BITS - 1);
    localparam logic            StopLast  = 1'(STOP_BITS - 1);
    localparam logic            OddBit    = 1'(PARITY_ODD);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]      wptr_q, rptr_q;
    logic [PtrW:0]        count_q, count_d;

    state_e               state_q;
    logic [CntW-1:0]      baud_q;
    logic [2:0]           bit_q;
    logic                 stop_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 tx_q;
    logic                 busy_q;

    logic                 full, empty, push, pop, baud_end, frame_end;
    logic [DATA_BITS-1:0] head;

    assign full      = (count_q == FullCount);
    assign empty     = (count_q == '0);
    assign push      = tx_valid && !full;
    assign baud_end  = (baud_q == BaudLast);
    assign frame_end = (state_q == StStop) && baud_end && (stop_q == StopLast);
    // Popping on the last stop cycle lets the next start bit follow with no idle gap.
    assign pop       = !empty && ((state_q == StIdle) || frame_end);
    assign head      = mem_q[rptr_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= tx_data;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else if (pop) begin
            state_q <= StStart;
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= head;
            par_q   <= (^head) ^ OddBit;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
                StStart: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        state_q <= StData;
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                StData: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (bit_q == BitLast) begin
                            if (PARITY_EN != 0) begin
                                state_q <= StParity;
                                tx_q    <= par_q;
                            end else begin
                                state_q <= StStop;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                StParity: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        state_q <= StStop;
                        tx_q    <= 1'b1;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                StStop: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (stop_q == StopLast) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end else begin
                            stop_q <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready   = !full;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;
    assign fifo_empty = empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: five configurations checked every cycle against a frame-level
// waveform model, plus hand-computed frame patterns and handshake timings.
module tb_uart_tx_fifo;

    localparam int NI    = 5;
    localparam int DEPTH = 4;
    localparam int CPB_A [NI] = '{50, 50, 50, 50, 3};
    localparam int DB_A  [NI] = '{8, 8, 8, 8, 5};
    localparam int PE_A  [NI] = '{0, 1, 1, 0, 1};
    localparam int ODD_A [NI] = '{0, 0, 1, 0, 1};
    localparam int SB_A  [NI] = '{1, 1, 1, 2, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [NI-1:0] valid;
    logic [7:0]    data [NI];
    logic [NI-1:0] tx_w, busy_w, ready_w, empty_w;
    logic [2:0]    cnt_w [NI];
    logic [NI-1:0] m_tx, m_busy;
    logic [2:0]    m_cnt [NI];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int nprint = 0;

    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
        localparam int C   = CPB_A[gi];
        localparam int DB  = DB_A[gi];
        localparam int PE  = PE_A[gi];
        localparam int ODD = ODD_A[gi];
        localparam int SB  = SB_A[gi];

        uart_tx_fifo #(
            .CLKS_PER_BIT(C),
            .DATA_BITS   (DB),
            .FIFO_DEPTH  (DEPTH),
            .PARITY_EN   (PE),
            .PARITY_ODD  (ODD),
            .STOP_BITS   (SB)
        ) u_dut (
            .sys_clk   (clk),
            .sys_rst   (rst),
            .tx_data   (data[gi][DB-1:0]),
            .tx_valid  (valid[gi]),
            .tx_ready  (ready_w[gi]),
            .tx        (tx_w[gi]),
            .busy      (busy_w[gi]),
            .fifo_count(cnt_w[gi]),
            .fifo_empty(empty_w[gi])
        );

        // Model: queue of accepted words plus the remaining per-cycle line levels of the frame.
        int       q[$];
        bit       lv[$];
        logic     etx   = 1'b1;
        logic     ebusy = 1'b0;
        logic [2:0] ecnt = '0;

        always @(posedge clk) begin
            bit acc;
            bit p;
            int w;
            if (rst) begin
                q.delete();
                lv.delete();
                etx   <= 1'b1;
                ebusy <= 1'b0;
                ecnt  <= '0;
            end else begin
                acc = valid[gi] && (q.size() < DEPTH);
                if (lv.size() > 0) void'(lv.pop_front());
                if (lv.size() == 0 && q.size() > 0) begin
                    w = q.pop_front();
                    for (int c = 0; c < C; c++) lv.push_back(1'b0);
                    for (int k = 0; k < DB; k++)
                        for (int c = 0; c < C; c++) lv.push_back(w[k]);
                    if (PE != 0) begin
                        p = (^w) ^ (ODD != 0);
                        for (int c = 0; c < C; c++) lv.push_back(p);
                    end
                    for (int c = 0; c < SB * C; c++) lv.push_back(1'b1);
                end
                if (acc) q.push_back(int'(data[gi]) & ((1 << DB) - 1));
                etx   <= (lv.size() > 0) ? lv[0] : 1'b1;
                ebusy <= (lv.size() > 0);
                ecnt  <= 3'(q.size());
            end
        end

        assign m_tx[gi]   = etx;
        assign m_busy[gi] = ebusy;
        assign m_cnt[gi]  = ecnt;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (nprint < 40)
                $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
            nprint++;
        end
    endtask

    // One clock: advance to the falling edge, then compare every instance with its model.
    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("i%0d tx", i),    int'(tx_w[i]),    int'(m_tx[i]));
            chk($sformatf("i%0d busy", i),  int'(busy_w[i]),  int'(m_busy[i]));
            chk($sformatf("i%0d count", i), int'(cnt_w[i]),   int'(m_cnt[i]));
            chk($sformatf("i%0d ready", i), int'(ready_w[i]), int'(m_cnt[i] != 3'd4));
            chk($sformatf("i%0d empty", i), int'(empty_w[i]), int'(m_cnt[i] == 3'd0));
        end
    endtask

    // Called at cycle 0 of a frame; returns at the first cycle after it.
    task automatic check_frame(input int i, input logic [15:0] bits, input int n, input int cpb,
                               input bit more);
        for (int t = 0; t < n * cpb; t++) begin
            if (t % cpb == 0 || t % cpb == cpb / 2)
                chk($sformatf("i%0d frame bit %0d", i, t / cpb), int'(tx_w[i]),
                    int'(bits[t / cpb]));
            if (t == 0 || t == n * cpb - 1)
                chk($sformatf("i%0d frame busy t%0d", i, t), int'(busy_w[i]), 1);
            tick();
        end
        chk($sformatf("i%0d busy after frame", i), int'(busy_w[i]), int'(more));
        chk($sformatf("i%0d tx after frame", i), int'(tx_w[i]), int'(!more));
    endtask

    initial begin
        int t1;
        int n;
        rst   = 1'b1;
        valid = '0;
        for (int i = 0; i < NI; i++) data[i] = 8'h00;
        repeat (5) tick();
        rst = 1'b0;
        tick();
        chk("reset tx", int'(tx_w[0]), 1);
        chk("reset busy", int'(busy_w[0]), 0);
        chk("reset ready", int'(ready_w[0]), 1);
        chk("reset count", int'(cnt_w[0]), 0);
        chk("reset empty", int'(empty_w[0]), 1);

        // Single frame 0xD9: line stays high at the push edge, falls one edge later.
        data[0]  = 8'hD9;
        valid[0] = 1'b1;
        tick();
        valid[0] = 1'b0;
        data[0]  = 8'h00;
        chk("single tx at push edge", int'(tx_w[0]), 1);
        chk("single count at push edge", int'(cnt_w[0]), 1);
        tick();
        check_frame(0, 16'h03B2, 10, 50, 1'b0);

        // Back-to-back with a full FIFO: words 1..5 go in on consecutive edges.
        valid[0] = 1'b1;
        t1 = 0;
        for (int w = 1; w <= 5; w++) begin
            data[0] = 8'(w);
            chk($sformatf("b2b ready word %0d", w), int'(ready_w[0]), 1);
            tick();
            if (w == 1) t1 = cyc;
        end
        chk("b2b count full", int'(cnt_w[0]), 4);
        chk("b2b ready full", int'(ready_w[0]), 0);
        data[0] = 8'h06;
        n = 0;
        while (!ready_w[0] && n < 600) begin
            tick();
            n++;
        end
        tick();
        valid[0] = 1'b0;
        chk("b2b word 6 accept cycle", cyc - t1, 502);
        chk("b2b count after word 6", int'(cnt_w[0]), 4);
        n = 0;
        while (busy_w[0] && n < 3200) begin
            tick();
            n++;
        end
        chk("b2b busy span end", cyc - t1, 3001);
        chk("b2b drained", int'(cnt_w[0]), 0);

        // Parity even then odd, 0xD9 has five ones.
        data[1]  = 8'hD9;
        valid[1] = 1'b1;
        tick();
        valid[1] = 1'b0;
        tick();
        check_frame(1, 16'h07B2, 11, 50, 1'b0);
        data[2]  = 8'hD9;
        valid[2] = 1'b1;
        tick();
        valid[2] = 1'b0;
        tick();
        check_frame(2, 16'h05B2, 11, 50, 1'b0);

        // Two stop bits between back-to-back frames 0x00 and 0xFF.
        data[3]  = 8'h00;
        valid[3] = 1'b1;
        tick();
        data[3] = 8'hFF;
        tick();
        valid[3] = 1'b0;
        check_frame(3, 16'h0600, 11, 50, 1'b1);
        check_frame(3, 16'h07FE, 11, 50, 1'b0);

        // Short configuration: 5 data bits, odd parity, 2 stops, 3 clocks per bit.
        data[4]  = 8'h1F;
        valid[4] = 1'b1;
        tick();
        data[4] = 8'hEA;
        tick();
        valid[4] = 1'b0;
        check_frame(4, 16'h01BE, 9, 3, 1'b1);
        check_frame(4, 16'h01D4, 9, 3, 1'b0);

        // Reset during data bit 3 of 0xA5 with two words queued.
        valid[0] = 1'b1;
        data[0]  = 8'hA5;
        tick();
        data[0] = 8'h3C;
        tick();
        data[0] = 8'h5A;
        tick();
        valid[0] = 1'b0;
        repeat (219) tick();
        chk("midrst queued", int'(cnt_w[0]), 2);
        chk("midrst busy before", int'(busy_w[0]), 1);
        chk("midrst tx data bit 3", int'(tx_w[0]), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst tx", int'(tx_w[0]), 1);
        chk("midrst count", int'(cnt_w[0]), 0);
        chk("midrst busy", int'(busy_w[0]), 0);
        chk("midrst empty", int'(empty_w[0]), 1);
        n = 0;
        for (int k = 0; k < 1200; k++) begin
            tick();
            if (busy_w[0] || !tx_w[0]) n++;
        end
        chk("midrst quiet cycles", n, 0);
        data[0]  = 8'h96;
        valid[0] = 1'b1;
        tick();
        valid[0] = 1'b0;
        tick();
        check_frame(0, 16'h032C, 10, 50, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
